fir_interp: RTL and testbench

FIR_INTERP -- requirements
Module: fir_interp

---
 rtl/fir_pkg.sv | 39 +++
 rtl/fir_interp.sv | 142 ++++++++++++++
 tb/tb_fir_interp.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the polyphase interpolating FIR.
// Holds the FSM state type, the Q10 dequantisation helper and the prototype filter coefficients.
// Contains no logic of its own; imported by fir_interp.
package fir_pkg;

    localparam int DEFAULT_TAPS          = 32;
    localparam int DEFAULT_INTERPOLATION = 4;
    localparam int DEFAULT_DATA_SIZE     = 32;

    // Samples and coefficients are Q10: the integer value is the real value times 1024.
    localparam int Q_SHIFT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2
    } state_t;

    // Prototype low-pass filter, signed Q10. Entry h[p + L*k] is used by phase p, tap k.
    localparam logic signed [DEFAULT_DATA_SIZE-1:0] AUDIO_INTERP_COEFFS [0:DEFAULT_TAPS-1] = '{
          32'sd3,   -32'sd5,  -32'sd12,  -32'sd18,  -32'sd20,  -32'sd12,    32'sd8,   32'sd40,
         32'sd78,  32'sd115,  32'sd142,  32'sd150,  32'sd134,   32'sd95,   32'sd40,  -32'sd20,
        -32'sd20,   32'sd40,   32'sd95,  32'sd134,  32'sd150,  32'sd142,  32'sd115,   32'sd78,
         32'sd40,    32'sd8,  -32'sd12,  -32'sd20,  -32'sd18,  -32'sd12,   -32'sd5,    32'sd3
    };

    // Q10 -> integer scale with rounding toward zero. Negative values are handled on the
    // magnitude so that e.g. -3 maps to 0 rather than the -1 an arithmetic shift would give.
    // The magnitude is kept unsigned so the most negative value still shifts correctly.
    function automatic logic signed [DEFAULT_DATA_SIZE-1:0] deq(
        input logic signed [DEFAULT_DATA_SIZE-1:0] v
    );
        logic [DEFAULT_DATA_SIZE-1:0] mag;
        mag = v[DEFAULT_DATA_SIZE-1] ? (~v + 1'b1) : v;
        mag = mag >> Q_SHIFT;
        deq = v[DEFAULT_DATA_SIZE-1] ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: each input sample yields INTERPOLATION output samples, one MAC per cycle.
// Latency: pop in cycle t gives the phase-0 write strobe in cycle t+K+2; one input per L*(K+1)+1 cycles.
// Backpressure: a full downstream FIFO holds the FSM in WRITE with the result frozen; no input is popped meanwhile.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   x_in, x_empty       upstream FIFO head sample (signed Q10) and its empty flag
//   x_rd_en             combinational pop strobe to the upstream FIFO (only ever in IDLE)
//   y_out, y_wr_en      registered output sample (signed Q10) and one-cycle push strobe
//   y_out_full          downstream FIFO full flag
module fir_interp
    import fir_pkg::*;
#(
    parameter int TAPS          = DEFAULT_TAPS,
    parameter int INTERPOLATION = DEFAULT_INTERPOLATION,
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] x_in,
    input  logic                        x_empty,
    output logic                        x_rd_en,
    output logic signed [DATA_SIZE-1:0] y_out,
    input  logic                        y_out_full,
    output logic                        y_wr_en
);

    localparam int K  = TAPS / INTERPOLATION;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [KW-1:0] TAP_LAST   = KW'(K - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(INTERPOLATION - 1);

    state_t state;
    state_t state_next;

    // Sample history, hist[0] newest.
    logic signed [DATA_SIZE-1:0] hist [K];
    logic signed [DATA_SIZE-1:0] acc;
    logic [PW-1:0]               phase;
    logic [KW-1:0]               tap;

    logic [CW-1:0]               coef_idx;
    logic signed [DATA_SIZE-1:0] coef;
    logic signed [DATA_SIZE-1:0] prod;

    // Phase p uses every L-th coefficient starting at p; tap k pairs it with the k-th newest sample.
    // The product is evaluated at DATA_SIZE width, so its upper bits are discarded before scaling.
    always_comb begin
        coef_idx = CW'(int'(phase) + INTERPOLATION * int'(tap));
        coef     = AUDIO_INTERP_COEFFS[coef_idx];
        prod     = coef * hist[tap];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational pop strobe. The pop is masked while reset is held so
    // a non-empty upstream FIFO is never drained during reset.
    always_comb begin
        state_next = state;
        x_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (!x_empty && !reset) begin
                    x_rd_en    = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (tap == TAP_LAST) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!y_out_full) begin
                    state_next = (phase == PHASE_LAST) ? IDLE : COMPUTE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: history shift on pop, MAC during COMPUTE, output register on WRITE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                hist[i] <= '0;
            end
            acc     <= '0;
            phase   <= '0;
            tap     <= '0;
            y_out   <= '0;
            y_wr_en <= 1'b0;
        end else begin
            y_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (x_rd_en) begin
                        for (int i = K - 1; i > 0; i--) begin
                            hist[i] <= hist[i-1];
                        end
                        hist[0] <= x_in;
                        phase   <= '0;
                        tap     <= '0;
                        acc     <= '0;
                    end
                end
                COMPUTE: begin
                    acc <= acc + deq(prod);
                    tap <= (tap == TAP_LAST) ? '0 : tap + 1'b1;
                end
                WRITE: begin
                    // While the downstream FIFO is full the accumulator simply holds.
                    if (!y_out_full) begin
                        y_out   <= acc;
                        y_wr_en <= 1'b1;
                        if (phase != PHASE_LAST) begin
                            phase <= phase + 1'b1;
                            acc   <= '0;
                            tap   <= '0;
                        end
                    end
                end
                default: begin
                    acc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp.sv
// Self-checking bench for fir_interp: upstream FIFO model, convolution scoreboard, directed scenarios.
module tb_fir_interp;

    localparam int L  = 4;
    localparam int K  = 8;
    localparam int NT = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic signed [31:0] x_in;
    logic               x_empty;
    logic               x_rd_en;
    logic signed [31:0] y_out;
    logic               y_out_full;
    logic               y_wr_en;

    always #5 clock = ~clock;

    fir_interp #(
        .TAPS          (32),
        .INTERPOLATION (4),
        .DATA_SIZE     (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .x_in       (x_in),
        .x_empty    (x_empty),
        .x_rd_en    (x_rd_en),
        .y_out      (y_out),
        .y_out_full (y_out_full),
        .y_wr_en    (y_wr_en)
    );

    // Independent copy of the prototype filter.
    int h_ref [NT] = '{
          3,  -5, -12, -18, -20, -12,   8,  40,
         78, 115, 142, 150, 134,  95,  40, -20,
        -20,  40,  95, 134, 150, 142, 115,  78,
         40,   8, -12, -20, -18, -12,  -5,   3
    };

    int hist_m [K];
    int in_q  [$];
    int exp_q [$];
    int got_q [$];
    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int rd_cyc   = 0;
    int wr_count = 0;
    int rd_count = 0;
    bit rd_pending = 1'b0;
    bit stalled    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Integer division truncates toward zero, which is exactly the required Q10 rounding.
    function automatic int deq_m(input int v);
        return v / 1024;
    endfunction

    // One input sample -> L outputs: y[p] = sum_k deq(h[p+L*k] * x[k]), all in wrapping 32-bit int.
    function automatic void model_consume(input int s);
        int acc;
        for (int k = K - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = s;
        for (int p = 0; p < L; p++) begin
            acc = 0;
            for (int k = 0; k < K; k++) acc += deq_m(h_ref[p + L*k] * hist_m[k]);
            exp_q.push_back(acc);
        end
    endfunction

    // Compare process: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clock) begin
        int e;
        cyc++;
        if (reset) begin
            check("reset_x_rd_en", int'(x_rd_en), 0);
            check("reset_y_wr_en", int'(y_wr_en), 0);
            check("reset_y_out", y_out, 0);
            exp_q.delete();
            foreach (hist_m[i]) hist_m[i] = 0;
        end else begin
            if (y_wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", int'(y_wr_en), 0);
                end else begin
                    if (exp_q.size() == L && !stalled)
                        check("phase0_latency", cyc - rd_cyc, K + 2);
                    e = exp_q.pop_front();
                    check("y_out", y_out, e);
                    got_q.push_back(y_out);
                end
            end
            if (x_rd_en) begin
                rd_count++;
                check("read_with_outputs_pending", exp_q.size(), 0);
                check("read_while_empty", int'(x_empty), 0);
                model_consume(x_in);
                rd_pending = 1'b1;
                rd_cyc     = cyc;
                stalled    = 1'b0;
            end
            if (y_out_full) stalled = 1'b1;
        end
    end

    task automatic drive();
        x_empty = (in_q.size() == 0);
        if (in_q.size() > 0) x_in = in_q[0];
        else                 x_in = 0;
    endtask

    // Advance one cycle; inputs change just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (rd_pending) begin
            if (in_q.size() > 0) void'(in_q.pop_front());
            rd_pending = 1'b0;
        end
        drive();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || rd_pending) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_within_budget", int'(n < 3000), 1);
        repeat (2) tick();
    endtask

    task automatic wait_read();
        int n = 0;
        int r0 = rd_count;
        while (rd_count == r0 && n < 200) begin
            tick();
            n++;
        end
        check("read_within_budget", int'(n < 200), 1);
    endtask

    task automatic load_impulse();
        in_q.push_back(1024);
        repeat (8) in_q.push_back(0);
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;

        // Reset with a non-empty upstream FIFO: nothing may be popped or written.
        reset      = 1'b1;
        y_out_full = 1'b0;
        in_q.push_back(77);
        drive();
        repeat (3) tick();
        in_q.delete();
        drive();
        tick();
        reset = 1'b0;
        tick();

        // Impulse: the output stream is the coefficient sequence, then zeros.
        got_q.delete();
        load_impulse();
        wait_drain();
        check("impulse_count", got_q.size(), 36);
        if (got_q.size() == 36) begin
            check("impulse_h0", got_q[0], 3);
            check("impulse_h11", got_q[11], 150);
            check("impulse_h15", got_q[15], -20);
            check("impulse_h31", got_q[31], 3);
            check("impulse_tail", got_q[35], 0);
        end

        // DC 1024: once the history is full each phase yields its polyphase coefficient sum.
        got_q.delete();
        repeat (10) in_q.push_back(1024);
        drive();
        wait_drain();
        check("dc_count", got_q.size(), 40);
        if (got_q.size() == 40) begin
            check("dc_phase0", got_q[36], 347);
            check("dc_phase1", got_q[37], 371);
            check("dc_phase2", got_q[38], 371);
            check("dc_phase3", got_q[39], 347);
        end

        // Backpressure: full for the first 5 cycles of the phase-0 WRITE.
        got_q.delete();
        in_q.push_back(1024);
        drive();
        wait_read();
        repeat (K) tick();
        y_out_full = 1'b1;
        w0 = wr_count;
        r0 = rd_count;
        repeat (5) tick();
        y_out_full = 1'b0;
        check("stall_no_write", wr_count - w0, 0);
        check("stall_no_read", rd_count - r0, 0);
        repeat (2) tick();
        check("stall_write_after_release", wr_count - w0, 1);
        wait_drain();
        if (got_q.size() > 0) check("stall_value", got_q[0], 347);

        // Starvation: empty upstream keeps the block idle.
        w0 = wr_count;
        r0 = rd_count;
        repeat (20) tick();
        check("starve_no_write", wr_count - w0, 0);
        check("starve_no_read", rd_count - r0, 0);

        // Negative rounding toward zero, from a cleared history.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        got_q.delete();
        in_q.push_back(-1);
        in_q.push_back(-1000);
        drive();
        wait_drain();
        check("neg_count", got_q.size(), 8);
        if (got_q.size() == 8) begin
            check("neg_minus1_phase0", got_q[0], 0);
            check("neg_minus1_phase3", got_q[3], 0);
            check("neg_minus1000_phase0", got_q[4], -2);
            check("neg_minus1000_phase1", got_q[5], 4);
        end

        // Reset after 3 MACs: the partial result is dropped and the history restarts at zero.
        in_q.push_back(500);
        drive();
        wait_read();
        repeat (3) tick();
        reset = 1'b1;
        w0 = wr_count;
        in_q.delete();
        drive();
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("abort_no_stale_write", wr_count - w0, 0);
        got_q.delete();
        load_impulse();
        wait_drain();
        check("post_abort_count", got_q.size(), 36);
        if (got_q.size() == 36) begin
            check("post_abort_h1", got_q[1], -5);
            check("post_abort_h8", got_q[8], 78);
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
